// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Memory-side bus between the multicycle controller and the unified
// instruction/data memory.
//   mem_req   : controller requests an access this cycle
//   memwrite  : write strobe (valid while mem_req is high)
//   iord      : address select, 0 = PC, 1 = aluout
//   mem_ready : memory completes the current access this cycle
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic memwrite;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output memwrite, output iord, input mem_ready);
    modport slave  (input mem_req, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore sequencing controller for a multicycle MIPS datapath with a unified
// memory and a shared ALU. Steps fetch/decode/execute/memory/writeback and
// drives all datapath enables and mux selects.
// Ports:
//   clk, reset (async, active low)
//   op, funct      : instruction fields from the IR
//   zero           : ALU zero flag (for beq)
//   mem            : memory bus (mem_req, memwrite, iord out; mem_ready in)
//   irwrite, pcen, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc,
//   alucontrol     : datapath controls
//   illegal        : one-cycle pulse on unsupported op or funct
//   state          : current FSM state (debug)
// Parameter MEM_HANDSHAKE: 1 = memory states wait for mem_ready,
//   0 = mem_ready ignored (every memory access takes one cycle).
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [5:0]                   op,
    input  logic [5:0]                   funct,
    input  logic                         zero,
    mips_multicycle_ctrl_if.master       mem,
    output logic                         irwrite,
    output logic                         pcen,
    output logic                         regwrite,
    output logic                         regdst,
    output logic                         memtoreg,
    output logic                         alusrca,
    output logic [1:0]                   alusrcb,
    output logic [1:0]                   pcsrc,
    output logic [2:0]                   alucontrol,
    output logic                         illegal,
    output logic [3:0]                   state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state_reg;

    // Effective handshake: without handshaking every access completes at once.
    logic ready;
    assign ready = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;

    // Funct decode for R-type execute.
    logic [2:0] funct_alu;
    logic       funct_ok;
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default: begin
                funct_alu = ALU_ADD;
                funct_ok  = 1'b0;
            end
        endcase
    end

    // State register and next-state logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:   if (ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_reg <= S_MEMADR;
                        OP_RTYPE:     state_reg <= S_RTYPEEX;
                        OP_BEQ:       state_reg <= S_BEQEX;
                        OP_ADDI:      state_reg <= S_ADDIEX;
                        OP_J:         state_reg <= S_JEX;
                        default:      state_reg <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_reg <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (ready) state_reg <= S_MEMWB;
                S_MEMWB:   state_reg <= S_FETCH;
                S_MEMWR:   if (ready) state_reg <= S_FETCH;
                S_RTYPEEX: state_reg <= S_RTYPEWB;
                S_RTYPEWB: state_reg <= S_FETCH;
                S_BEQEX:   state_reg <= S_FETCH;
                S_ADDIEX:  state_reg <= S_ADDIWB;
                S_ADDIWB:  state_reg <= S_FETCH;
                S_JEX:     state_reg <= S_FETCH;
                default:   state_reg <= S_FETCH;
            endcase
        end
    end

    // Ungated control values decoded from the current state.
    logic mem_req_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;
    logic pcwrite, branch;
    always_comb begin
        mem_req_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        mem.iord     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                alusrcb     = 2'b01;
                // PC and IR load only on the handshake cycle.
                irwrite_raw = ready;
                pcwrite     = ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_raw = 1'b0;
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req_raw = 1'b1;
                mem.iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                mem_req_raw  = 1'b1;
                memwrite_raw = 1'b1;
                mem.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca     = 1'b1;
                alucontrol  = funct_alu;
                illegal_raw = ~funct_ok;
            end
            S_RTYPEWB: begin
                // funct is still held in the IR, so an unsupported funct
                // can cancel the write-back here.
                regwrite_raw = funct_ok;
                regdst       = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            S_JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: begin
                alusrcb = 2'b00;
            end
        endcase
    end

    // Strobes are forced low asynchronously while reset is held, so an
    // aborted access never issues another write or register update.
    assign mem.mem_req  = reset & mem_req_raw;
    assign mem.memwrite = reset & memwrite_raw;
    assign irwrite      = reset & irwrite_raw;
    assign pcen         = reset & (pcwrite | (branch & zero));
    assign regwrite     = reset & regwrite_raw;
    assign illegal      = reset & illegal_raw;
    assign state        = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if ifc ();
    mips_multicycle_ctrl_if ifc2 ();

    logic       irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       irwrite2, pcen2, regwrite2, regdst2, memtoreg2, alusrca2, illegal2;
    logic [1:0] alusrcb2, pcsrc2;
    logic [2:0] alucontrol2;
    logic [3:0] state2;

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(ifc.master),
        .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    // Second instance without handshaking; its mem_ready is held low.
    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(ifc2.master),
        .irwrite(irwrite2), .pcen(pcen2), .regwrite(regwrite2), .regdst(regdst2),
        .memtoreg(memtoreg2), .alusrca(alusrca2), .alusrcb(alusrcb2), .pcsrc(pcsrc2),
        .alucontrol(alucontrol2), .illegal(illegal2), .state(state2)
    );

    initial ifc.mem_ready = 1'b1;
    initial ifc2.mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] o);
        return (o == 6'h23) || (o == 6'h2b) || (o == 6'h00) || (o == 6'h04) ||
               (o == 6'h08) || (o == 6'h02);
    endfunction

    // Sequence of states an instruction walks through (ignoring wait states).
    function automatic void path_of(input logic [5:0] o, output int p[$]);
        p = {0, 1};
        case (o)
            6'h23: p = {0, 1, 2, 3, 4};
            6'h2b: p = {0, 1, 2, 5};
            6'h00: p = {0, 1, 6, 7};
            6'h04: p = {0, 1, 8};
            6'h08: p = {0, 1, 9, 10};
            6'h02: p = {0, 1, 11};
            default: p = {0, 1};
        endcase
    endfunction

    function automatic bit is_mem_state(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    // Expected outputs in state s; alucontrol is only meaningful where the
    // ALU operation is defined (other states report care = 0).
    function automatic obs_t model(input int s, input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic r, output bit alu_care);
        obs_t e;
        int a;
        e = '0;
        e.st = 4'(s);
        alu_care = 1'b1;
        case (s)
            0: begin e.mem_req = 1; e.alusrcb = 2'b01; e.alucontrol = 3'd2; e.irwrite = r; e.pcen = r; end
            1: begin e.alusrcb = 2'b11; e.alucontrol = 3'd2; e.illegal = !op_known(o); end
            2: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'd2; end
            3: begin e.mem_req = 1; e.iord = 1; alu_care = 0; end
            4: begin e.regwrite = 1; e.memtoreg = 1; alu_care = 0; end
            5: begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; alu_care = 0; end
            6: begin
                a = alu_of_funct(f);
                e.alusrca = 1;
                e.alucontrol = (a < 0) ? 3'd2 : 3'(a);
                e.illegal = (a < 0);
            end
            7: begin e.regwrite = (alu_of_funct(f) >= 0); e.regdst = 1; alu_care = 0; end
            8: begin e.alusrca = 1; e.alucontrol = 3'd6; e.pcsrc = 2'b01; e.pcen = z; end
            9: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'd2; end
            10: begin e.regwrite = 1; alu_care = 0; end
            11: begin e.pcen = 1; e.pcsrc = 2'b10; alu_care = 0; end
            default: alu_care = 0;
        endcase
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = '{st: state, mem_req: ifc.mem_req, memwrite: ifc.memwrite, iord: ifc.iord,
              irwrite: irwrite, pcen: pcen, regwrite: regwrite, regdst: regdst,
              memtoreg: memtoreg, alusrca: alusrca, alusrcb: alusrcb, pcsrc: pcsrc,
              alucontrol: alucontrol, illegal: illegal};
        return o;
    endfunction

    // ---------------- helpers ----------------
    // Called at posedge+1; returns at posedge+1 with the DUT in FETCH.
    task automatic do_reset();
        reset = 1'b0;
        ifc.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Runs one instruction starting in FETCH (at posedge+1), with random
    // memory wait states, checking every cycle against the model.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int stall_pct);
        int p[$];
        int idx;
        int cyc;
        obs_t e, g;
        bit care;
        op = o; funct = f; zero = z;
        path_of(o, p);
        idx = 0;
        cyc = 0;
        while (idx < p.size() && cyc < 200) begin
            ifc.mem_ready = ($urandom_range(99) >= stall_pct);
            #5;
            e = model(p[idx], o, f, z, ifc.mem_ready, care);
            g = observe();
            if (!care) begin
                e.alucontrol = 3'd0;
                g.alucontrol = 3'd0;
            end
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL instr op=%b funct=%b step=%0d: got %h expected %h", o, f, idx, g, e);
            end
            if (!(is_mem_state(p[idx]) && !ifc.mem_ready)) idx++;
            cyc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cyc >= 200) begin
            failures++;
            $display("FAIL instr_timeout op=%b: got %0d cycles required < 200", o, cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #5;
            checks++;
            if (state !== 4'd0 || ifc.mem_req !== 1'b0 || ifc.memwrite !== 1'b0 || irwrite !== 1'b0 ||
                pcen !== 1'b0 || regwrite !== 1'b0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: got state=%0d req=%b wr=%b ir=%b pcen=%b rw=%b ill=%b required 0,all 0",
                         state, ifc.mem_req, ifc.memwrite, irwrite, pcen, regwrite, illegal);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #5;
        checks++;
        if (state !== 4'd0 || ifc.mem_req !== 1'b1 || irwrite !== 1'b1 || pcen !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got state=%0d req=%b ir=%b pcen=%b required 0,1,1,1",
                     state, ifc.mem_req, irwrite, pcen);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_fetch_stall();
        op = 6'h02;
        for (int i = 0; i < 4; i++) begin
            ifc.mem_ready = (i == 3);
            #5;
            checks++;
            if (ifc.mem_req !== 1'b1 || irwrite !== (i == 3) || pcen !== (i == 3) || state !== 4'd0) begin
                failures++;
                $display("FAIL fetch_stall cycle %0d: got req=%b ir=%b pcen=%b state=%0d required 1,%0d,%0d,0",
                         i, ifc.mem_req, irwrite, pcen, state, (i == 3), (i == 3));
            end
            @(posedge clk);
            #1;
        end
        #5;
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL fetch_stall_decode: got state=%0d required 1", state);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_directed();
        logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        run_instr(6'h23, 6'h00, 1'b0, 0);
        run_instr(6'h2b, 6'h00, 1'b0, 0);
        for (int i = 0; i < 5; i++) run_instr(6'h00, fl[i], 1'b0, 0);
        run_instr(6'h00, 6'h00, 1'b0, 0);
        run_instr(6'h04, 6'h11, 1'b1, 0);
        run_instr(6'h04, 6'h11, 1'b0, 0);
        run_instr(6'h08, 6'h2a, 1'b0, 0);
        run_instr(6'h02, 6'h00, 1'b1, 0);
        run_instr(6'h3f, 6'h20, 1'b0, 0);
    endtask

    task automatic test_latency();
        logic [5:0] ops [6] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h04, 6'h02};
        int lat [6] = '{5, 4, 4, 4, 3, 3};
        int n;
        ifc.mem_ready = 1'b1;
        funct = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            op = ops[i];
            n = 1;
            @(posedge clk);
            #1;
            while (state !== 4'd0 && n < 20) begin
                n++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (n !== lat[i]) begin
                failures++;
                $display("FAIL latency op=%b: got %0d cycles required %0d", ops[i], n, lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] o, f;
        int k;
        for (int t = 0; t < 60; t++) begin
            k = $urandom_range(7);
            f = 6'($urandom);
            case (k)
                0: o = 6'h23;
                1: o = 6'h2b;
                2: begin o = 6'h00; f = fl[$urandom_range(4)]; end
                3: o = 6'h00;
                4: o = 6'h04;
                5: o = 6'h08;
                6: o = 6'h02;
                default: begin
                    o = 6'($urandom);
                    for (int j = 0; j < 20 && op_known(o); j++) o = 6'($urandom);
                    if (op_known(o)) o = 6'h3f;
                end
            endcase
            run_instr(o, f, 1'($urandom), 35);
        end
    endtask

    task automatic test_abort();
        run_instr(6'h23, 6'h00, 1'b0, 0);
        op = 6'h2b;
        ifc.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ifc.mem_ready = 1'b0;
        #4;
        checks++;
        if (state !== 4'd5 || ifc.memwrite !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: got state=%0d memwrite=%b required 5,1", state, ifc.memwrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ifc.memwrite !== 1'b0 || ifc.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL abort: got state=%0d memwrite=%b mem_req=%b required 0,0,0",
                     state, ifc.memwrite, ifc.mem_req);
        end
        @(posedge clk);
        #1;
        do_reset();
        run_instr(6'h08, 6'h00, 1'b0, 20);
    endtask

    task automatic test_no_handshake();
        int exp_seq [6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        op = 6'h23;
        ifc.mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #5;
            checks++;
            if (state2 !== 4'(exp_seq[i])) begin
                failures++;
                $display("FAIL nohs_state cycle %0d: got %0d required %0d", i, state2, exp_seq[i]);
            end
            if (i == 0) begin
                checks++;
                if (irwrite2 !== 1'b1 || ifc2.mem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL nohs_fetch: got ir=%b req=%b required 1,1", irwrite2, ifc2.mem_req);
                end
            end
            @(posedge clk);
            #1;
        end
        do_reset();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_stall();
        test_directed();
        test_latency();
        test_random();
        test_abort();
        test_no_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main sequencing controller for a multicycle MIPS datapath. The datapath shares one unified instruction/data memory and one ALU across several cycles per instruction. This block decodes op/funct, steps a Moore FSM through fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select. Memory accesses use a req/ready handshake, so the core tolerates variable-latency memory.

Parameters:
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current access this cycle
mem_req  output  1  memory access requested this cycle
memwrite  output  1  write strobe to the unified memory
iord  output  1  memory address select: 0 = PC, 1 = aluout
irwrite  output  1  load the instruction register
pcen  output  1  PC load enable
regwrite  output  1  register file write enable
regdst  output  1  destination select: 0 = rt, 1 = rd
memtoreg  output  1  write-back select: 0 = aluout, 1 = data register
alusrca  output  1  ALU A select: 0 = PC, 1 = A register
alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  output  2  next-PC select: 00 = ALU result, 01 = aluout, 10 = jump target
alucontrol  output  3  ALU operation code
illegal  output  1  one-cycle pulse on an unsupported opcode or funct
state  output  4  current FSM state (debug)

Behaviour:
- Reset (reset = 0, asynchronous): state = FETCH (0).
  - While reset = 0, force mem_req, memwrite, irwrite, pcen, regwrite and illegal to 0.
  - All other outputs take their FETCH values.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 are unreachable; if entered, return to FETCH.
- All outputs are combinational from state, except as noted. pcen = pcwrite | (branch & zero).
- FETCH:
  - Outputs: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = add, pcsrc = 00.
  - irwrite and pcwrite = mem_ready. PC and IR update only on the handshake cycle.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, aluop = add (branch target computed into aluout).
  - Next state by op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → RTYPEEX
    - 000100 (beq) → BEQEX
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JEX
    - any other op → FETCH, with illegal = 1 for this cycle.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1. Next state FETCH.
- MEMWR: mem_req = 1, memwrite = 1, iord = 1. memwrite is held until mem_ready; the access completes on that cycle. Next state FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = funct-decoded. Next state RTYPEWB.
- RTYPEWB: regwrite = 1, regdst = 1, memtoreg = 0. Next state FETCH.
  - If funct is unsupported: illegal = 1 in RTYPEEX, regwrite is suppressed in RTYPEWB, and the FSM still returns to FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = sub, branch = 1, pcsrc = 01. Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = add. Next state ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next state FETCH.
- JEX: pcwrite = 1, pcsrc = 10. Next state FETCH.
- ALU decode:
  - aluop add → 010; aluop sub → 110.
  - funct-decoded: 100000 → 010 (add), 100010 → 110 (sub), 100100 → 000 (and), 100101 → 001 (or), 101010 → 111 (slt), any other funct → 010 with illegal.
- Unlisted outputs default to 0 in every state.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe is issued after the reset edge.
- MEM_HANDSHAKE = 0: FETCH, MEMRD and MEMWR each last exactly one cycle.
- Resulting latencies with zero wait states:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles

Test Plan:
- Reset: hold reset = 0 for 3 cycles with mem_ready = 1 → state = 0 and all strobes 0. Release reset → FETCH issues mem_req = 1, irwrite = 1, pcen = 1 in the first cycle.
- Fetch stall: mem_ready = 0 for 3 cycles, then 1 → mem_req high for 4 cycles; irwrite and pcen pulse exactly once, on the 4th cycle; DECODE is entered on the next cycle.
- lw: op = 100011, mem_ready tied to 1 → state sequence 0, 1, 2, 3, 4, 0. In state 4: regwrite = 1, memtoreg = 1. sw: op = 101011 → states 0, 1, 2, 5, 0, with memwrite = 1 only in state 5.
- R-type: op = 0 with funct = 100000, 100010, 100100, 100101, 101010 → alucontrol 010, 110, 000, 001, 111 in RTYPEEX; regwrite = 1, regdst = 1 in RTYPEWB. funct = 000000 → illegal pulse and no regwrite.
- beq: op = 000100 with zero = 1 → pcen = 1, pcsrc = 01 in BEQEX. With zero = 0 → pcen = 0. j: op = 000010 → pcen = 1, pcsrc = 10 in JEX; 3 cycles total.
- Abort: assert reset = 0 during MEMWR while mem_ready = 0 → memwrite drops asynchronously and state = 0. Illegal op = 111111 → illegal pulses in DECODE and the FSM returns to FETCH.
